// File: rtl/ds_openhpsdr1_depack.sv
// ds_openhpsdr1_depack
// Byte-serial parser for the OpenHPSDR protocol-1 downstream (PC->card)
// stream. It recognises start/stop packets and EP2 data packets, then splits
// each EP2 frame into command words, L/R audio samples and TX I/Q samples.
//
// Handshakes: a byte moves on ds_stream, and a sample moves on tx_*, on a
// rising clk edge where both valid and ready are 1. A producer keeps valid
// and data stable until that edge. lr_tvalid and cmd_rqst are one-cycle strobes
// and have no ready. The input stalls only while a TX sample waits for the
// downstream, so a new sample can never overwrite one that has not been taken.
module ds_openhpsdr1_depack #(
    parameter int SEQ_CHECK = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ds_stream,
    input  logic        ds_stream_valid,
    output logic        ds_stream_ready,
    output logic [31:0] tx_tdata,
    output logic        tx_tvalid,
    input  logic        tx_tready,
    output logic [31:0] lr_tdata,
    output logic        lr_tvalid,
    output logic [5:0]  cmd_addr,
    output logic [31:0] cmd_data,
    output logic        cmd_rqst,
    output logic        ptt,
    output logic        run,
    output logic        wide_spectrum,
    output logic        seq_err,
    output logic        sync_err,
    output logic [3:0]  dbg_state
);

    localparam logic [3:0] S_HUNT0     = 4'd0;
    localparam logic [3:0] S_HUNT1     = 4'd1;
    localparam logic [3:0] S_TYPE      = 4'd2;
    localparam logic [3:0] S_EP        = 4'd3;
    localparam logic [3:0] S_SEQ       = 4'd4;
    localparam logic [3:0] S_SYNC      = 4'd5;
    localparam logic [3:0] S_CC        = 4'd6;
    localparam logic [3:0] S_AUDIO     = 4'd7;
    localparam logic [3:0] S_IQ        = 4'd8;
    localparam logic [3:0] S_STARTSTOP = 4'd9;

    logic [3:0]  state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;        // byte index inside the current field
    logic [5:0]  smp_q, smp_d;        // sample index inside a frame, 0..62
    logic        frame_q, frame_d;    // 0 = first 512-byte frame, 1 = second
    logic [23:0] buf_q, buf_d;        // last three accepted bytes
    logic [6:0]  c0_q, c0_d;          // C0[6:0] held until C4 arrives
    logic [31:0] exp_q, exp_d;        // next expected EP2 sequence number
    logic        first_q, first_d;    // next EP2 sequence is taken unchecked
    logic [31:0] tx_data_q, tx_data_d;
    logic        tx_valid_q, tx_valid_d;
    logic [31:0] lr_data_q, lr_data_d;
    logic        lr_valid_q, lr_valid_d;
    logic [5:0]  cmd_addr_q, cmd_addr_d;
    logic [31:0] cmd_data_q, cmd_data_d;
    logic        cmd_rqst_q, cmd_rqst_d;
    logic        ptt_q, ptt_d;
    logic        run_q, run_d;
    logic        wide_q, wide_d;
    logic        seq_err_q, seq_err_d;
    logic        sync_err_q, sync_err_d;

    logic        acc;
    logic [31:0] word;

    assign ds_stream_ready = ~(tx_valid_q & ~tx_tready);
    assign acc             = ds_stream_valid & ds_stream_ready;
    // Big-endian 32-bit word completed by the byte being accepted now.
    assign word            = {buf_q, ds_stream};

    // Next-state and output-register logic; state moves only on accepted bytes.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        smp_d      = smp_q;
        frame_d    = frame_q;
        buf_d      = buf_q;
        c0_d       = c0_q;
        exp_d      = exp_q;
        first_d    = first_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        lr_data_d  = lr_data_q;
        lr_valid_d = 1'b0;
        cmd_addr_d = cmd_addr_q;
        cmd_data_d = cmd_data_q;
        cmd_rqst_d = 1'b0;
        ptt_d      = ptt_q;
        run_d      = run_q;
        wide_d     = wide_q;
        seq_err_d  = 1'b0;
        sync_err_d = 1'b0;

        if (tx_valid_q && tx_tready) begin
            tx_valid_d = 1'b0;
        end

        if (acc) begin
            buf_d = {buf_q[15:0], ds_stream};
            case (state_q)
                S_HUNT0: begin
                    if (ds_stream == 8'hEF) state_d = S_HUNT1;
                end
                S_HUNT1: begin
                    // A repeated 0xEF restarts the header match in place.
                    if (ds_stream == 8'hFE)      state_d = S_TYPE;
                    else if (ds_stream == 8'hEF) state_d = S_HUNT1;
                    else                         state_d = S_HUNT0;
                end
                S_TYPE: begin
                    if (ds_stream == 8'h01) begin
                        state_d = S_EP;
                    end else if (ds_stream == 8'h04) begin
                        state_d = S_STARTSTOP;
                        cnt_d   = 6'd60;
                    end else begin
                        state_d = S_HUNT0;
                    end
                end
                S_EP: begin
                    cnt_d   = 6'd0;
                    state_d = (ds_stream == 8'h02) ? S_SEQ : S_HUNT0;
                end
                S_SEQ: begin
                    if (cnt_q == 6'd3) begin
                        if ((SEQ_CHECK != 0) && !first_q && (word != exp_q)) begin
                            seq_err_d = 1'b1;
                        end
                        exp_d   = word + 32'd1;
                        first_d = 1'b0;
                        frame_d = 1'b0;
                        cnt_d   = 6'd0;
                        state_d = S_SYNC;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_SYNC: begin
                    if (ds_stream != 8'h7F) begin
                        sync_err_d = 1'b1;
                        cnt_d      = 6'd0;
                        state_d    = S_HUNT0;
                    end else if (cnt_q == 6'd2) begin
                        cnt_d   = 6'd0;
                        state_d = S_CC;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_CC: begin
                    if (cnt_q == 6'd0) c0_d = ds_stream[6:0];
                    if (cnt_q == 6'd4) begin
                        cmd_addr_d = c0_q[6:1];
                        cmd_data_d = word;
                        ptt_d      = c0_q[0];
                        cmd_rqst_d = 1'b1;
                        cnt_d      = 6'd0;
                        smp_d      = 6'd0;
                        state_d    = S_AUDIO;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_AUDIO: begin
                    if (cnt_q == 6'd3) begin
                        lr_data_d  = word;
                        lr_valid_d = 1'b1;
                        cnt_d      = 6'd0;
                        state_d    = S_IQ;
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_IQ: begin
                    if (cnt_q == 6'd3) begin
                        tx_data_d  = word;
                        tx_valid_d = 1'b1;
                        cnt_d      = 6'd0;
                        if (smp_q == 6'd62) begin
                            smp_d = 6'd0;
                            if (!frame_q) begin
                                frame_d = 1'b1;
                                state_d = S_SYNC;
                            end else begin
                                state_d = S_HUNT0;
                            end
                        end else begin
                            smp_d   = smp_q + 6'd1;
                            state_d = S_AUDIO;
                        end
                    end else begin
                        cnt_d = cnt_q + 6'd1;
                    end
                end
                S_STARTSTOP: begin
                    // cnt counts the bytes still to consume, first byte at 60.
                    if (cnt_q == 6'd60) begin
                        run_d  = ds_stream[0];
                        wide_d = ds_stream[1];
                        if (ds_stream[0] && !run_q) first_d = 1'b1;
                    end
                    if (cnt_q == 6'd1) begin
                        cnt_d   = 6'd0;
                        state_d = S_HUNT0;
                    end else begin
                        cnt_d = cnt_q - 6'd1;
                    end
                end
                default: begin
                    cnt_d   = 6'd0;
                    state_d = S_HUNT0;
                end
            endcase
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_HUNT0;
            cnt_q      <= 6'd0;
            smp_q      <= 6'd0;
            frame_q    <= 1'b0;
            buf_q      <= 24'd0;
            c0_q       <= 7'd0;
            exp_q      <= 32'd0;
            first_q    <= 1'b1;
            tx_data_q  <= 32'd0;
            tx_valid_q <= 1'b0;
            lr_data_q  <= 32'd0;
            lr_valid_q <= 1'b0;
            cmd_addr_q <= 6'd0;
            cmd_data_q <= 32'd0;
            cmd_rqst_q <= 1'b0;
            ptt_q      <= 1'b0;
            run_q      <= 1'b0;
            wide_q     <= 1'b0;
            seq_err_q  <= 1'b0;
            sync_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            smp_q      <= smp_d;
            frame_q    <= frame_d;
            buf_q      <= buf_d;
            c0_q       <= c0_d;
            exp_q      <= exp_d;
            first_q    <= first_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            lr_data_q  <= lr_data_d;
            lr_valid_q <= lr_valid_d;
            cmd_addr_q <= cmd_addr_d;
            cmd_data_q <= cmd_data_d;
            cmd_rqst_q <= cmd_rqst_d;
            ptt_q      <= ptt_d;
            run_q      <= run_d;
            wide_q     <= wide_d;
            seq_err_q  <= seq_err_d;
            sync_err_q <= sync_err_d;
        end
    end

    assign tx_tdata      = tx_data_q;
    assign tx_tvalid     = tx_valid_q;
    assign lr_tdata      = lr_data_q;
    assign lr_tvalid     = lr_valid_q;
    assign cmd_addr      = cmd_addr_q;
    assign cmd_data      = cmd_data_q;
    assign cmd_rqst      = cmd_rqst_q;
    assign ptt           = ptt_q;
    assign run           = run_q;
    assign wide_spectrum = wide_q;
    assign seq_err       = seq_err_q;
    assign sync_err      = sync_err_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_ds_openhpsdr1_depack.sv
// Testbench for ds_openhpsdr1_depack: packet builder drives bytes and pushes
// the expected commands, audio and TX samples; a negedge monitor pops and
// compares them as the DUT emits them.
module tb_ds_openhpsdr1_depack;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ds_stream = 8'h00;
    logic        ds_stream_valid = 1'b0;
    logic        ds_stream_ready;
    logic [31:0] tx_tdata;
    logic        tx_tvalid;
    logic        tx_tready;
    logic [31:0] lr_tdata;
    logic        lr_tvalid;
    logic [5:0]  cmd_addr;
    logic [31:0] cmd_data;
    logic        cmd_rqst;
    logic        ptt;
    logic        run;
    logic        wide_spectrum;
    logic        seq_err;
    logic        sync_err;
    logic [3:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] exp_tx_q[$];
    logic [31:0] exp_lr_q[$];
    logic [38:0] exp_cmd_q[$];

    int tx_cnt = 0, lr_cnt = 0, cmd_cnt = 0, seq_err_cnt = 0, sync_err_cnt = 0;
    logic prev_cmd = 1'b0, prev_lr = 1'b0, prev_seq = 1'b0, prev_sync = 1'b0;
    int tready_mode = 0;

    ds_openhpsdr1_depack #(.SEQ_CHECK(1)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ds_stream       (ds_stream),
        .ds_stream_valid (ds_stream_valid),
        .ds_stream_ready (ds_stream_ready),
        .tx_tdata        (tx_tdata),
        .tx_tvalid       (tx_tvalid),
        .tx_tready       (tx_tready),
        .lr_tdata        (lr_tdata),
        .lr_tvalid       (lr_tvalid),
        .cmd_addr        (cmd_addr),
        .cmd_data        (cmd_data),
        .cmd_rqst        (cmd_rqst),
        .ptt             (ptt),
        .run             (run),
        .wide_spectrum   (wide_spectrum),
        .seq_err         (seq_err),
        .sync_err        (sync_err),
        .dbg_state       (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // tx_tready changes 2 ns after posedge so negedge sampling sees it stable.
    initial begin : tready_drv
        tx_tready = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (tready_mode)
                0:       tx_tready = 1'b1;
                1:       tx_tready = ($urandom_range(0, 3) != 0);
                default: tx_tready = 1'b0;
            endcase
        end
    end

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        logic [31:0] e32;
        logic [38:0] e39;
        if (tx_tvalid === 1'b1 && tx_tready === 1'b1) begin
            tx_cnt++;
            vectors++;
            if (exp_tx_q.size() == 0) begin
                miscompares++;
                $display("FAIL tx_unexpected: got %08h, expected no sample", tx_tdata);
            end else begin
                e32 = exp_tx_q.pop_front();
                if (tx_tdata !== e32) begin
                    miscompares++;
                    $display("FAIL tx_data: got %08h, expected %08h", tx_tdata, e32);
                end
            end
        end
        if (lr_tvalid === 1'b1) begin
            lr_cnt++;
            vectors++;
            if (exp_lr_q.size() == 0) begin
                miscompares++;
                $display("FAIL lr_unexpected: got %08h, expected no sample", lr_tdata);
            end else begin
                e32 = exp_lr_q.pop_front();
                if (lr_tdata !== e32) begin
                    miscompares++;
                    $display("FAIL lr_data: got %08h, expected %08h", lr_tdata, e32);
                end
            end
        end
        if (cmd_rqst === 1'b1) begin
            cmd_cnt++;
            vectors++;
            if (exp_cmd_q.size() == 0) begin
                miscompares++;
                $display("FAIL cmd_unexpected: got addr %02h data %08h", cmd_addr, cmd_data);
            end else begin
                e39 = exp_cmd_q.pop_front();
                if ({ptt, cmd_addr, cmd_data} !== e39) begin
                    miscompares++;
                    $display("FAIL cmd_word: got ptt %0b addr %02h data %08h, expected ptt %0b addr %02h data %08h",
                             ptt, cmd_addr, cmd_data, e39[38], e39[37:32], e39[31:0]);
                end
            end
        end
        if (seq_err === 1'b1)  seq_err_cnt++;
        if (sync_err === 1'b1) sync_err_cnt++;
        if ((cmd_rqst === 1'b1) || (lr_tvalid === 1'b1) || (seq_err === 1'b1) || (sync_err === 1'b1)) begin
            vectors++;
            if ((cmd_rqst === 1'b1 && prev_cmd) || (lr_tvalid === 1'b1 && prev_lr) ||
                (seq_err === 1'b1 && prev_seq) || (sync_err === 1'b1 && prev_sync)) begin
                miscompares++;
                $display("FAIL strobe_width: a strobe stayed high two cycles, got 1 expected 0");
            end
        end
        prev_cmd  = (cmd_rqst === 1'b1);
        prev_lr   = (lr_tvalid === 1'b1);
        prev_seq  = (seq_err === 1'b1);
        prev_sync = (sync_err === 1'b1);
    end

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        ds_stream       = b;
        ds_stream_valid = 1'b1;
        #1;
        while (ds_stream_ready !== 1'b1 && n < 1000) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 1000) begin
            vectors++;
            miscompares++;
            $display("FAIL byte_accept_timeout: ready stuck at %0b, expected 1", ds_stream_ready);
        end
        @(negedge clk);
        ds_stream_valid = 1'b0;
    endtask

    task automatic send_start(input logic [7:0] cmd);
        send_byte(8'hEF);
        send_byte(8'hFE);
        send_byte(8'h04);
        send_byte(cmd);
        for (int i = 0; i < 60; i++) send_byte(8'h00);
    endtask

    // Sends an EP2 packet (or its first stop_at bytes); bad_frame selects a
    // frame whose third sync byte is corrupted, after which sending stops.
    task automatic send_ep2(input logic [31:0] seq, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] c4,
                            input logic [15:0] base, input int bad_frame, input int stop_at);
        logic [7:0]  b;
        logic [7:0]  cb[5];
        logic [15:0] l, r, si, sq;
        int f, o, p, k;
        bit stop;
        cb[0] = c0; cb[1] = c1; cb[2] = c2; cb[3] = c3; cb[4] = c4;
        for (int idx = 0; idx < stop_at; idx++) begin
            stop = 1'b0;
            if (idx < 4) begin
                case (idx)
                    0:       b = 8'hEF;
                    1:       b = 8'hFE;
                    2:       b = 8'h01;
                    default: b = 8'h02;
                endcase
            end else if (idx < 8) begin
                b = 8'(seq >> (8 * (7 - idx)));
            end else begin
                f = (idx - 8) / 512;
                o = (idx - 8) % 512;
                if (o < 3) begin
                    if (f == bad_frame && o == 2) begin
                        b    = 8'h00;
                        stop = 1'b1;
                    end else begin
                        b = 8'h7F;
                    end
                end else if (o < 8) begin
                    b = cb[o - 3];
                    if (o == 7) exp_cmd_q.push_back({c0[0], c0[6:1], c1, c2, c3, c4});
                end else begin
                    p  = o - 8;
                    k  = f * 63 + p / 8;
                    l  = base + 16'(4 * k);
                    r  = base + 16'(4 * k + 1);
                    si = base + 16'(4 * k + 2);
                    sq = base + 16'(4 * k + 3);
                    case (p % 8)
                        0:       b = l[15:8];
                        1:       b = l[7:0];
                        2:       b = r[15:8];
                        3:       b = r[7:0];
                        4:       b = si[15:8];
                        5:       b = si[7:0];
                        6:       b = sq[15:8];
                        default: b = sq[7:0];
                    endcase
                    if (p % 8 == 3) exp_lr_q.push_back({l, r});
                    if (p % 8 == 7) exp_tx_q.push_back({si, sq});
                end
            end
            send_byte(b);
            if (stop) break;
        end
    endtask

    task automatic wait_drain(input string name);
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            if (exp_tx_q.size() == 0 && exp_lr_q.size() == 0 && exp_cmd_q.size() == 0) break;
        end
        vectors++;
        if (exp_tx_q.size() != 0 || exp_lr_q.size() != 0 || exp_cmd_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: pending tx %0d lr %0d cmd %0d, expected 0 0 0",
                     name, exp_tx_q.size(), exp_lr_q.size(), exp_cmd_q.size());
        end
    endtask

    task automatic apply_reset();
        rst_n           = 1'b0;
        ds_stream_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n           = 1'b0;
        ds_stream_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (ds_stream_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_ready: got %0b, expected 1", ds_stream_ready);
        end
        vectors++;
        if ({tx_tvalid, lr_tvalid, cmd_rqst, seq_err, sync_err, ptt, run, wide_spectrum} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_flags: got %08b, expected 00000000",
                     {tx_tvalid, lr_tvalid, cmd_rqst, seq_err, sync_err, ptt, run, wide_spectrum});
        end
        vectors++;
        if ({cmd_addr, cmd_data, tx_tdata, lr_tdata} !== 102'd0) begin
            miscompares++;
            $display("FAIL reset_data: got addr %02h cmd %08h tx %08h lr %08h, expected all 0",
                     cmd_addr, cmd_data, tx_tdata, lr_tdata);
        end
        vectors++;
        if (dbg_state !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d, expected 0", dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_start();
        send_byte(8'hEF);
        send_byte(8'hFE);
        send_byte(8'h04);
        vectors++;
        if (run !== 1'b0) begin
            miscompares++;
            $display("FAIL start_run_early: got %0b, expected 0", run);
        end
        send_byte(8'h03);
        vectors++;
        if ({run, wide_spectrum} !== 2'b11) begin
            miscompares++;
            $display("FAIL start_run_wide: got %02b, expected 11", {run, wide_spectrum});
        end
        for (int i = 0; i < 60; i++) send_byte(8'h00);
        vectors++;
        if (dbg_state !== 4'd0) begin
            miscompares++;
            $display("FAIL start_end_state: got %0d, expected 0", dbg_state);
        end
        send_start(8'h00);
        vectors++;
        if ({run, wide_spectrum} !== 2'b00) begin
            miscompares++;
            $display("FAIL stop_run_wide: got %02b, expected 00", {run, wide_spectrum});
        end
        send_start(8'h01);
        vectors++;
        if ({run, wide_spectrum} !== 2'b10) begin
            miscompares++;
            $display("FAIL start_run_only: got %02b, expected 10", {run, wide_spectrum});
        end
    endtask

    task automatic test_ep2_basic();
        int t0, l0, c0n, s0;
        t0 = tx_cnt; l0 = lr_cnt; c0n = cmd_cnt; s0 = seq_err_cnt;
        send_ep2(32'd0, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 16'h1000, -1, 1032);
        wait_drain("basic");
        vectors++;
        if ({tx_cnt - t0, lr_cnt - l0, cmd_cnt - c0n} !== {32'd126, 32'd126, 32'd2}) begin
            miscompares++;
            $display("FAIL basic_counts: got tx %0d lr %0d cmd %0d, expected 126 126 2",
                     tx_cnt - t0, lr_cnt - l0, cmd_cnt - c0n);
        end
        vectors++;
        if ({ptt, cmd_addr, cmd_data} !== {1'b1, 6'd0, 32'h12345678}) begin
            miscompares++;
            $display("FAIL basic_cmd_hold: got ptt %0b addr %02h data %08h, expected 1 00 12345678",
                     ptt, cmd_addr, cmd_data);
        end
        vectors++;
        if (seq_err_cnt != s0 || dbg_state !== 4'd0) begin
            miscompares++;
            $display("FAIL basic_seq_state: got seq_err %0d state %0d, expected 0 0",
                     seq_err_cnt - s0, dbg_state);
        end
    endtask

    task automatic test_seq();
        logic [31:0] seqs[6];
        int exp_err[6];
        int s0;
        seqs[0] = 32'd5;        exp_err[0] = 0;
        seqs[1] = 32'd7;        exp_err[1] = 1;
        seqs[2] = 32'd8;        exp_err[2] = 0;
        seqs[3] = 32'hFFFFFFFF; exp_err[3] = 0;
        seqs[4] = 32'd0;        exp_err[4] = 0;
        seqs[5] = 32'd1;        exp_err[5] = 0;
        send_start(8'h00);
        send_start(8'h01);
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                send_start(8'h00);
                send_start(8'h01);
            end
            s0 = seq_err_cnt;
            send_ep2(seqs[i], 8'h02, 8'hA0, 8'hA1, 8'hA2, 8'h00 + 8'(i), 16'(16'h2000 + 16'(i * 512)), -1, 1032);
            wait_drain("seq");
            vectors++;
            if (seq_err_cnt - s0 != exp_err[i]) begin
                miscompares++;
                $display("FAIL seq_err_pkt%0d: got %0d pulses, expected %0d", i, seq_err_cnt - s0, exp_err[i]);
            end
        end
    endtask

    task automatic test_sync();
        int t0, y0, s0;
        t0 = tx_cnt; y0 = sync_err_cnt; s0 = seq_err_cnt;
        send_ep2(32'd2, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 16'h3000, 1, 1032);
        wait_drain("sync_bad");
        vectors++;
        if (sync_err_cnt - y0 != 1 || tx_cnt - t0 != 63 || dbg_state !== 4'd0) begin
            miscompares++;
            $display("FAIL sync_bad: got sync_err %0d tx %0d state %0d, expected 1 63 0",
                     sync_err_cnt - y0, tx_cnt - t0, dbg_state);
        end
        t0 = tx_cnt;
        send_ep2(32'd3, 8'h06, 8'h55, 8'h66, 8'h77, 8'h88, 16'h4000, -1, 1032);
        wait_drain("sync_good");
        vectors++;
        if (sync_err_cnt - y0 != 1 || seq_err_cnt != s0 || tx_cnt - t0 != 126) begin
            miscompares++;
            $display("FAIL sync_recover: got sync_err %0d seq_err %0d tx %0d, expected 1 0 126",
                     sync_err_cnt - y0, seq_err_cnt - s0, tx_cnt - t0);
        end
    endtask

    task automatic test_back_to_back_stall();
        int t0;
        bit saw_valid;
        t0 = tx_cnt;
        saw_valid = 1'b0;
        fork
            send_ep2(32'd4, 8'h08, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 16'h5000, -1, 1032);
            begin
                for (int n = 0; n < 5000 && tx_cnt - t0 < 30; n++) @(negedge clk);
                tready_mode = 2;
                @(negedge clk);
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    vectors++;
                    if (tx_tvalid === 1'b1) saw_valid = 1'b1;
                    if (ds_stream_ready !== ~tx_tvalid) begin
                        miscompares++;
                        $display("FAIL stall_ready: got %0b with tx_tvalid %0b, expected %0b",
                                 ds_stream_ready, tx_tvalid, ~tx_tvalid);
                    end
                end
                tready_mode = 0;
            end
        join
        wait_drain("stall");
        vectors++;
        if (!saw_valid || tx_cnt - t0 != 126) begin
            miscompares++;
            $display("FAIL stall_count: got saw_valid %0b tx %0d, expected 1 126", saw_valid, tx_cnt - t0);
        end
    endtask

    task automatic test_random_backpressure();
        int t0, s0;
        t0 = tx_cnt; s0 = seq_err_cnt;
        tready_mode = 1;
        send_ep2(32'd5, 8'h3A, 8'(($urandom_range(0, 255))), 8'h5A, 8'hC3, 8'h0F,
                 16'($urandom_range(0, 65535)), -1, 1032);
        tready_mode = 0;
        wait_drain("random");
        vectors++;
        if ({ptt, cmd_addr} !== {1'b0, 6'h1D} || tx_cnt - t0 != 126 || seq_err_cnt != s0) begin
            miscompares++;
            $display("FAIL random_bp: got ptt %0b addr %02h tx %0d seq_err %0d, expected 0 1d 126 0",
                     ptt, cmd_addr, tx_cnt - t0, seq_err_cnt - s0);
        end
    endtask

    task automatic test_reset_mid_packet();
        int s0, t0;
        send_ep2(32'd6, 8'h01, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 16'h6000, -1, 500);
        rst_n           = 1'b0;
        ds_stream_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({tx_tvalid, lr_tvalid, cmd_rqst, seq_err, sync_err, ptt, run, wide_spectrum} !== 8'h00 ||
            {cmd_addr, cmd_data, tx_tdata, lr_tdata} !== 102'd0 || dbg_state !== 4'd0 ||
            ds_stream_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_values: got flags %08b ready %0b state %0d, expected 00000000 1 0",
                     {tx_tvalid, lr_tvalid, cmd_rqst, seq_err, sync_err, ptt, run, wide_spectrum},
                     ds_stream_ready, dbg_state);
        end
        rst_n = 1'b1;
        @(negedge clk);
        wait_drain("midreset");
        s0 = seq_err_cnt; t0 = tx_cnt;
        send_ep2(32'd100, 8'h01, 8'h01, 8'h02, 8'h03, 8'h04, 16'h7000, -1, 1032);
        wait_drain("after_reset");
        vectors++;
        if (seq_err_cnt != s0 || tx_cnt - t0 != 126 || run !== 1'b0) begin
            miscompares++;
            $display("FAIL after_reset: got seq_err %0d tx %0d run %0b, expected 0 126 0",
                     seq_err_cnt - s0, tx_cnt - t0, run);
        end
        s0 = seq_err_cnt;
        send_ep2(32'd50, 8'h01, 8'h01, 8'h02, 8'h03, 8'h05, 16'h7100, -1, 1032);
        wait_drain("after_reset_bad");
        vectors++;
        if (seq_err_cnt - s0 != 1) begin
            miscompares++;
            $display("FAIL after_reset_check: got %0d seq_err pulses, expected 1", seq_err_cnt - s0);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_start();
        test_ep2_basic();
        test_seq();
        test_sync();
        test_back_to_back_stall();
        test_random_backpressure();
        test_reset_mid_packet();
        apply_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
